adder_stage: RTL and testbench

- Registered two's-complement adder for the TP3 pipeline datapath: PC increment, branch target computation, and generic A+B.
- Computes A+B modulo 2^NB_DATA and the carry, signed-overflow and zero flags.
- Result and flags are registered, giving one cycle of latency, with a valid strobe alongside.
- Wraps a purely combinational sum core so that other stages can reuse the core on its own.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/adder_stage_if.sv | 34 +++
 rtl/adder_core.sv | 34 +++
 rtl/adder_stage.sv | 78 +++++++
 tb/tb_adder_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the TP3 pipeline datapath.
//   NB_DATA          : default datapath width in bits
//   signed_overflow  : two's-complement overflow rule for an addition, given
//                      the sign bits of both operands and of the sum
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int NB_DATA = 32;

  // Overflow happens only when both operands share a sign and the sum's
  // sign differs from it; mixed-sign additions can never overflow.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage : pipeline_pkg

// File: rtl/adder_stage_if.sv
// ---------------------------------------------------------------------------
// adder_stage_if
// Operand/result bundle of the registered adder stage.
//   i_valid, i_data_A, i_data_B          : operands offered by the producer
//   o_result, o_valid, o_carry,
//   o_overflow, o_zero                   : registered sum and flags
// Modports:
//   master : the producer/consumer around the adder (drives operands)
//   slave  : the adder stage itself (drives result and flags)
// ---------------------------------------------------------------------------
interface adder_stage_if #(
  parameter int NB_DATA = pipeline_pkg::NB_DATA
) ();

  logic               i_valid;
  logic [NB_DATA-1:0] i_data_A;
  logic [NB_DATA-1:0] i_data_B;
  logic [NB_DATA-1:0] o_result;
  logic               o_valid;
  logic               o_carry;
  logic               o_overflow;
  logic               o_zero;

  modport master (
    output i_valid, i_data_A, i_data_B,
    input  o_result, o_valid, o_carry, o_overflow, o_zero
  );

  modport slave (
    input  i_valid, i_data_A, i_data_B,
    output o_result, o_valid, o_carry, o_overflow, o_zero
  );

endinterface : adder_stage_if

// File: rtl/adder_core.sv
// ---------------------------------------------------------------------------
// adder_core
// Purely combinational two's-complement adder, reusable by any stage.
//   i_data_A, i_data_B : operands (NB_DATA bits)
//   o_sum              : (A+B) mod 2^NB_DATA
//   o_carry            : carry out of the MSB (unsigned overflow)
//   o_overflow         : signed overflow
//   o_zero             : o_sum == 0
// ---------------------------------------------------------------------------
module adder_core #(
  parameter int NB_DATA = pipeline_pkg::NB_DATA
) (
  input  logic [NB_DATA-1:0] i_data_A,
  input  logic [NB_DATA-1:0] i_data_B,
  output logic [NB_DATA-1:0] o_sum,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_zero
);

  import pipeline_pkg::*;

  // One extra bit so the carry falls out of the same addition.
  logic [NB_DATA:0] sum_wide;

  assign sum_wide   = {1'b0, i_data_A} + {1'b0, i_data_B};
  assign o_sum      = sum_wide[NB_DATA-1:0];
  assign o_carry    = sum_wide[NB_DATA];
  assign o_overflow = signed_overflow(i_data_A[NB_DATA-1],
                                      i_data_B[NB_DATA-1],
                                      sum_wide[NB_DATA-1]);
  assign o_zero     = (sum_wide[NB_DATA-1:0] == '0);

endmodule : adder_core

// File: rtl/adder_stage.sv
// ---------------------------------------------------------------------------
// adder_stage
// Registered adder for the TP3 pipeline: one cycle of latency from operands
// to result/flags, with a valid strobe. Result and flags hold their last
// value while no new operands arrive; only o_valid drops.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset, clears every output
//   bus     : adder_stage_if slave (operands in, result and flags out)
// ---------------------------------------------------------------------------
module adder_stage #(
  parameter int NB_DATA = pipeline_pkg::NB_DATA
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  adder_stage_if.slave  bus
);

  import pipeline_pkg::*;

  logic [NB_DATA-1:0] core_sum;
  logic               core_carry;
  logic               core_overflow;
  logic               core_zero;

  logic [NB_DATA-1:0] result_q,   result_d;
  logic               valid_q,    valid_d;
  logic               carry_q,    carry_d;
  logic               overflow_q, overflow_d;
  logic               zero_q,     zero_d;

  adder_core #(.NB_DATA(NB_DATA)) u_core (
    .i_data_A   (bus.i_data_A),
    .i_data_B   (bus.i_data_B),
    .o_sum      (core_sum),
    .o_carry    (core_carry),
    .o_overflow (core_overflow),
    .o_zero     (core_zero)
  );

  // Result and flags only move when new operands arrive, so a consumer can
  // keep reading the last sum after the valid strobe drops.
  always_comb begin
    valid_d    = bus.i_valid;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    if (bus.i_valid) begin
      result_d   = core_sum;
      carry_d    = core_carry;
      overflow_d = core_overflow;
      zero_d     = core_zero;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q   <= '0;
      valid_q    <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      result_q   <= result_d;
      valid_q    <= valid_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.o_result   = result_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_zero     = zero_q;

endmodule : adder_stage

// File: tb/tb_adder_stage.sv
// ---------------------------------------------------------------------------
// tb_adder_stage
// Self-checking bench for adder_stage (NB_DATA = 32). Expected values come
// from plain integer arithmetic on the operands: a 64-bit unsigned sum for
// result/carry and a signed 64-bit sum range test for overflow.
// Outputs are packed as {valid, carry, overflow, zero, result} and sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_adder_stage;

  localparam int NB = 32;

  logic clk;
  logic rst_n;

  int checkCount = 0;
  int passCount  = 0;

  // Last sum the model expects the outputs to hold: {carry, ovf, zero, result}.
  logic [NB+2:0] heldExp;

  adder_stage_if #(.NB_DATA(NB)) bus ();

  adder_stage #(.NB_DATA(NB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result and flags from integer arithmetic, valid bit set.
  function automatic logic [NB+3:0] model_sum(input logic [NB-1:0] a,
                                               input logic [NB-1:0] b);
    longint unsigned u;
    longint          s;
    logic [NB-1:0]   r;
    logic            c, v, z;
    u = longint'(a) + longint'(b);
    s = longint'($signed(a)) + longint'($signed(b));
    r = u[NB-1:0];
    c = (u >= 64'h1_0000_0000);
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    z = (r == 0);
    return {1'b1, c, v, z, r};
  endfunction

  function automatic logic [NB+3:0] observed();
    return {bus.o_valid, bus.o_carry, bus.o_overflow, bus.o_zero, bus.o_result};
  endfunction

  task automatic test_reset();
    logic [NB+3:0] exp;
    rst_n        = 1'b0;
    bus.i_valid  = 1'b1;
    bus.i_data_A = 32'd5;
    bus.i_data_B = 32'd7;
    repeat (3) @(negedge clk);
    checkCount++;
    if (observed() !== '0)
      $display("[TB] FAIL reset_hold: got %h required %h", observed(), 36'h0);
    else passCount++;
    rst_n = 1'b1;
    @(negedge clk);
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0000000C};
    checkCount++;
    if (observed() !== exp)
      $display("[TB] FAIL reset_release: got %h required %h", observed(), exp);
    else passCount++;
    heldExp = exp[NB+2:0];
  endtask

  task automatic test_basic_wrap();
    logic [NB-1:0] as [2] = '{32'h00000001, 32'hFFFFFFFF};
    logic [NB-1:0] bs [2] = '{32'h00000001, 32'h00000001};
    logic [NB+3:0] req [2] = '{{4'b1000, 32'h00000002}, {4'b1101, 32'h00000000}};
    for (int i = 0; i < 2; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_data_A = as[i];
      bus.i_data_B = bs[i];
      @(negedge clk);
      checkCount++;
      if (observed() !== req[i])
        $display("[TB] FAIL basic_wrap[%0d]: got %h required %h", i, observed(), req[i]);
      else passCount++;
      heldExp = req[i][NB+2:0];
    end
  endtask

  task automatic test_signed_overflow();
    logic [NB-1:0] as [2] = '{32'h7FFFFFFF, 32'h80000000};
    logic [NB-1:0] bs [2] = '{32'h00000001, 32'hFFFFFFFF};
    logic [NB+3:0] req [2] = '{{4'b1010, 32'h80000000}, {4'b1110, 32'h7FFFFFFF}};
    for (int i = 0; i < 2; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_data_A = as[i];
      bus.i_data_B = bs[i];
      @(negedge clk);
      checkCount++;
      if (observed() !== req[i])
        $display("[TB] FAIL signed_ovf[%0d]: got %h required %h", i, observed(), req[i]);
      else passCount++;
      heldExp = req[i][NB+2:0];
    end
  endtask

  task automatic test_back_to_back();
    logic [NB+3:0] exp;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_data_A = $urandom;
      bus.i_data_B = $urandom;
      exp = model_sum(bus.i_data_A, bus.i_data_B);
      @(negedge clk);
      checkCount++;
      if (observed() !== exp)
        $display("[TB] FAIL stream[%0d]: got %h required %h", i, observed(), exp);
      else passCount++;
      heldExp = exp[NB+2:0];
    end
    // New operands without valid must not disturb the held sum.
    for (int i = 0; i < 2; i++) begin
      bus.i_valid  = 1'b0;
      bus.i_data_A = $urandom;
      bus.i_data_B = $urandom;
      @(negedge clk);
      checkCount++;
      if (observed() !== {1'b0, heldExp})
        $display("[TB] FAIL hold[%0d]: got %h required %h", i, observed(), {1'b0, heldExp});
      else passCount++;
    end
  endtask

  task automatic test_mid_reset();
    logic [NB+3:0] exp;
    bus.i_valid  = 1'b1;
    bus.i_data_A = 32'h12345678;
    bus.i_data_B = 32'h11111111;
    exp = model_sum(bus.i_data_A, bus.i_data_B);
    @(negedge clk);
    checkCount++;
    if (observed() !== exp)
      $display("[TB] FAIL pre_reset: got %h required %h", observed(), exp);
    else passCount++;
    bus.i_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkCount++;
    if (observed() !== '0)
      $display("[TB] FAIL async_reset: got %h required %h", observed(), 36'h0);
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkCount++;
    if (observed() !== '0)
      $display("[TB] FAIL post_reset_idle: got %h required %h", observed(), 36'h0);
    else passCount++;
    heldExp = '0;
  endtask

  task automatic test_random();
    logic [NB-1:0] corners [4] = '{32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [NB+3:0] exp;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.i_valid  = ($urandom_range(0, 7) != 0);
      bus.i_data_A = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      bus.i_data_B = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      if (bus.i_valid) begin
        exp = model_sum(bus.i_data_A, bus.i_data_B);
        heldExp = exp[NB+2:0];
      end else begin
        exp = {1'b0, heldExp};
      end
      @(negedge clk);
      checkCount++;
      if (observed() !== exp) begin
        errs++;
        if (errs <= 10)
          $display("[TB] FAIL random[%0d] A=%h B=%h: got %h required %h",
                   i, bus.i_data_A, bus.i_data_B, observed(), exp);
      end else passCount++;
    end
  endtask

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_data_A = '0;
    bus.i_data_B = '0;
    rst_n        = 1'b0;
    heldExp      = '0;
    test_reset();
    test_basic_wrap();
    test_signed_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_adder_stage
